aer_in_tx: RTL

AER input transmitter that sits between the host/stimulus side and the AERIN port of `ODIN_ffstdp`. The host pushes 12-bit input-neuron events into a small FIFO. The block replays each event on AERIN_ADDR/AERIN_REQ using a 4-phase handshake against AERIN_ACK. It also reports progress and errors: ACK timeout and FIFO overflow.

---
 rtl/aer_in_tx.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/aer_in_tx.sv
// aer_in_tx: buffers host-side AER events in a small FIFO and replays each one
// on the AERIN 4-phase REQ/ACK handshake toward the core. Reports completed
// events, ACK timeouts and dropped pushes.
module aer_in_tx #(
  parameter int unsigned AER_WIDTH   = 12,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EV_WR_EN,
  input  logic [AER_WIDTH-1:0] EV_WR_ADDR,
  output logic                 EV_FULL,
  output logic                 EV_EMPTY,
  input  logic                 CLR_ERR,
  output logic [AER_WIDTH-1:0] AERIN_ADDR,
  output logic                 AERIN_REQ,
  input  logic                 AERIN_ACK,
  output logic                 BUSY,
  output logic [CNT_WIDTH-1:0] SENT_CNT,
  output logic                 TIMEOUT_ERR,
  output logic                 OVF_ERR
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  // One extra pointer bit distinguishes full from empty when the indices match.
  localparam int unsigned PtrW  = AddrW + 1;
  // tcnt only ever needs to reach ACK_TIMEOUT-1.
  localparam int unsigned TcntW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [PtrW-1:0]      DepthCount = PtrW'(FIFO_DEPTH);
  localparam logic [TcntW-1:0]     TcntLast   = TcntW'(ACK_TIMEOUT - 1);
  localparam logic [TcntW-1:0]     TcntOne    = TcntW'(1);
  localparam logic [CNT_WIDTH-1:0] CntOne     = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitLow
  } state_e;

  // FIFO state
  logic [AER_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]      count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 push, pop, ovf_ev;
  logic [AER_WIDTH-1:0] fifo_head;

  // Handshake state
  state_e               state_q;
  logic                 req_q;
  logic [AER_WIDTH-1:0] addr_q;
  logic [TcntW-1:0]     tcnt_q;
  logic [CNT_WIDTH-1:0] sent_q;
  logic                 to_err_q;
  logic                 ovf_err_q;

  // A push against a full FIFO is dropped even if a pop frees a slot on the same edge.
  assign push      = EV_WR_EN & ~full_q;
  assign ovf_ev    = EV_WR_EN & full_q;
  assign pop       = (state_q == StIdle) & ~empty_q;
  assign fifo_head = mem_q[rd_ptr_q[AddrW-1:0]];

  // Next pointers and next occupancy flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{(PtrW-1){1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{(PtrW-1){1'b0}}, pop};
    count_d  = wr_ptr_d - rd_ptr_d;
    full_d   = (count_d == DepthCount);
    empty_d  = (count_d == '0);
  end

  // Event storage; contents are don't-care until written, so no reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= EV_WR_ADDR;
    end
  end

  // FIFO pointers and registered FULL/EMPTY flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Sticky overflow flag; a drop on the same edge as CLR_ERR keeps it set.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovf_err_q <= 1'b0;
    end else begin
      ovf_err_q <= (ovf_err_q & ~CLR_ERR) | ovf_ev;
    end
  end

  // Handshake FSM with registered REQ/ADDR, timeout counter and sent counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      req_q    <= 1'b0;
      addr_q   <= '0;
      tcnt_q   <= '0;
      sent_q   <= '0;
      to_err_q <= 1'b0;
    end else begin
      // Cleared first so that a timeout later in this block takes priority.
      if (CLR_ERR) begin
        to_err_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (!empty_q) begin
            addr_q  <= fifo_head;
            req_q   <= 1'b1;
            tcnt_q  <= '0;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (AERIN_ACK) begin
            req_q   <= 1'b0;
            sent_q  <= sent_q + CntOne;
            state_q <= StWaitLow;
          end else if (tcnt_q == TcntLast) begin
            req_q    <= 1'b0;
            to_err_q <= 1'b1;
            state_q  <= StWaitLow;
          end else begin
            tcnt_q <= tcnt_q + TcntOne;
          end
        end
        StWaitLow: begin
          // No timeout here: the core must eventually release ACK.
          if (!AERIN_ACK) begin
            state_q <= StIdle;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign EV_FULL     = full_q;
  assign EV_EMPTY    = empty_q;
  assign AERIN_ADDR  = addr_q;
  assign AERIN_REQ   = req_q;
  assign BUSY        = (state_q != StIdle) | ~empty_q;
  assign SENT_CNT    = sent_q;
  assign TIMEOUT_ERR = to_err_q;
  assign OVF_ERR     = ovf_err_q;

endmodule
